// File: rtl/au_arbiter_2ch.sv
// Two-requester round-robin front end for a single shared 4-bit add/subtract unit.
// One operation in flight at a time: IDLE accepts, EXEC computes, RESP holds the result until consumed.

module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    assign {cout, s} = 5'(a) + 5'(b) + 5'(cin);
endmodule

module au_arbiter_2ch #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          FIRST_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic             req_op_0,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    output logic             rsp_valid_0,
    input  logic             rsp_ready_0,
    output logic [WIDTH-1:0] rsp_result_0,
    output logic             rsp_flag_0,
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic             req_op_1,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_result_1,
    output logic             rsp_flag_1,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             last_grant;
    logic             gnt_q;
    logic             op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             any_valid;
    logic             grant_c;
    logic             accept_c;
    logic [WIDTH-1:0] au_b;
    logic [WIDTH-1:0] au_sum;
    logic             au_cout;
    logic             au_flag;

    // Tie goes to the requester that did not win last time.
    always_comb begin
        any_valid = req_valid_0 | req_valid_1;
        grant_c   = req_valid_1;
        if (req_valid_0 && req_valid_1) begin
            grant_c = ~last_grant;
        end
        accept_c    = !rst && (state == IDLE) && any_valid;
        req_ready_0 = accept_c && !grant_c;
        req_ready_1 = accept_c && grant_c;
    end

    // Subtract is A + ~B + 1; the carry then means "no borrow", hence the inversion.
    assign au_b    = op_q ? ~b_q : b_q;
    assign au_flag = op_q ? ~au_cout : au_cout;

    adder_4bit u_adder (
        .a    (a_q),
        .b    (au_b),
        .cin  (op_q),
        .s    (au_sum),
        .cout (au_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= ~FIRST_PRIO;
            gnt_q        <= 1'b0;
            op_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_0  <= 1'b0;
            rsp_valid_1  <= 1'b0;
            rsp_result_0 <= '0;
            rsp_result_1 <= '0;
            rsp_flag_0   <= 1'b0;
            rsp_flag_1   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt_q      <= grant_c;
                        last_grant <= grant_c;
                        op_q       <= grant_c ? req_op_1 : req_op_0;
                        a_q        <= grant_c ? req_a_1 : req_a_0;
                        b_q        <= grant_c ? req_b_1 : req_b_0;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (gnt_q) begin
                        rsp_result_1 <= au_sum;
                        rsp_flag_1   <= au_flag;
                        rsp_valid_1  <= 1'b1;
                    end else begin
                        rsp_result_0 <= au_sum;
                        rsp_flag_0   <= au_flag;
                        rsp_valid_0  <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (gnt_q ? rsp_ready_1 : rsp_ready_0) begin
                        rsp_valid_0 <= 1'b0;
                        rsp_valid_1 <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_au_arbiter_2ch.sv
// Scoreboard bench for au_arbiter_2ch: expected results are queued at acceptance
// and compared when the response handshake completes.

module tb_au_arbiter_2ch;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid_0 = 1'b0, req_op_0 = 1'b0, rsp_ready_0 = 1'b1;
    logic       req_valid_1 = 1'b0, req_op_1 = 1'b0, rsp_ready_1 = 1'b1;
    logic [3:0] req_a_0 = '0, req_b_0 = '0, req_a_1 = '0, req_b_1 = '0;
    logic       req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
    logic       rsp_flag_0, rsp_flag_1, busy;
    logic [3:0] rsp_result_0, rsp_result_1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    logic [5:0] sbq[$];
    int         glog[$];
    int         gcyc[$];
    int         acc_edge = 0;
    logic       prv0 = 1'b0, prv1 = 1'b0;

    au_arbiter_2ch #(.WIDTH(4), .FIRST_PRIO(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_0  (req_valid_0),
        .req_ready_0  (req_ready_0),
        .req_op_0     (req_op_0),
        .req_a_0      (req_a_0),
        .req_b_0      (req_b_0),
        .rsp_valid_0  (rsp_valid_0),
        .rsp_ready_0  (rsp_ready_0),
        .rsp_result_0 (rsp_result_0),
        .rsp_flag_0   (rsp_flag_0),
        .req_valid_1  (req_valid_1),
        .req_ready_1  (req_ready_1),
        .req_op_1     (req_op_1),
        .req_a_1      (req_a_1),
        .req_b_1      (req_b_1),
        .rsp_valid_1  (rsp_valid_1),
        .rsp_ready_1  (rsp_ready_1),
        .rsp_result_1 (rsp_result_1),
        .rsp_flag_1   (rsp_flag_1),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: {flag, result}; flag is carry on add, borrow (A<B) on subtract.
    function automatic logic [4:0] model(input logic op, input logic [3:0] a, input logic [3:0] b);
        int r;
        if (op) return {(a < b), 4'((int'(a) - int'(b) + 16) % 16)};
        r = int'(a) + int'(b);
        return {(r > 15), 4'(r % 16)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Negedge monitor: inputs and combinational ready are settled for the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                sbq.delete();
            end else begin
                if (req_valid_0 && req_ready_0) begin
                    sbq.push_back({1'b0, model(req_op_0, req_a_0, req_b_0)});
                    acc_edge = cyc + 1;
                    glog.push_back(0);
                    gcyc.push_back(cyc + 1);
                end
                if (req_valid_1 && req_ready_1) begin
                    sbq.push_back({1'b1, model(req_op_1, req_a_1, req_b_1)});
                    acc_edge = cyc + 1;
                    glog.push_back(1);
                    gcyc.push_back(cyc + 1);
                end
                if (rsp_valid_0 && !prv0) chk("latency0", cyc, acc_edge + 1);
                if (rsp_valid_1 && !prv1) chk("latency1", cyc, acc_edge + 1);
                if (rsp_valid_0 && rsp_valid_1) chk("both_rsp_valid", 1, 0);
                if (rsp_valid_0 && rsp_ready_0) begin
                    if (sbq.size() == 0) chk("unexpected_rsp0", 1, 0);
                    else begin
                        logic [5:0] e;
                        e = sbq.pop_front();
                        chk("rsp0_channel", 0, 32'(e[5]));
                        chk("rsp0_result", 32'(rsp_result_0), 32'(e[3:0]));
                        chk("rsp0_flag", 32'(rsp_flag_0), 32'(e[4]));
                    end
                end
                if (rsp_valid_1 && rsp_ready_1) begin
                    if (sbq.size() == 0) chk("unexpected_rsp1", 1, 0);
                    else begin
                        logic [5:0] e;
                        e = sbq.pop_front();
                        chk("rsp1_channel", 1, 32'(e[5]));
                        chk("rsp1_result", 32'(rsp_result_1), 32'(e[3:0]));
                        chk("rsp1_flag", 32'(rsp_flag_1), 32'(e[4]));
                    end
                end
            end
            prv0 = rsp_valid_0;
            prv1 = rsp_valid_1;
        end
    end

    // Present one request and hold it until accepted; operands are scrambled afterwards.
    task automatic send(input int ch, input logic op, input logic [3:0] a, input logic [3:0] b);
        logic acc;
        acc = 1'b0;
        if (ch == 0) begin req_valid_0 = 1'b1; req_op_0 = op; req_a_0 = a; req_b_0 = b; end
        else         begin req_valid_1 = 1'b1; req_op_1 = op; req_a_1 = a; req_b_1 = b; end
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = (ch == 0) ? req_ready_0 : req_ready_1;
            tick();
        end
        if (!acc) chk($sformatf("accept_timeout_ch%0d", ch), 0, 1);
        if (ch == 0) begin req_valid_0 = 1'b0; req_a_0 = ~a; req_b_0 = 4'($urandom); req_op_0 = ~op; end
        else         begin req_valid_1 = 1'b0; req_a_1 = ~a; req_b_1 = 4'($urandom); req_op_1 = ~op; end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            done = (sbq.size() == 0) && !busy && !rsp_valid_0 && !rsp_valid_1;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit d0, d1;

        // Reset held two cycles with both requesters asserting valid.
        req_valid_0 = 1'b1;
        req_valid_1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ready0", 32'(req_ready_0), 0);
            chk("rst_ready1", 32'(req_ready_1), 0);
            chk("rst_rsp_valid0", 32'(rsp_valid_0), 0);
            chk("rst_rsp_valid1", 32'(rsp_valid_1), 0);
            chk("rst_busy", 32'(busy), 0);
        end
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic add on channel 0: 9+8 wraps to 1 with carry.
        send(0, 1'b0, 4'd9, 4'd8);
        tick();
        chk("add_rsp_valid0", 32'(rsp_valid_0), 1);
        chk("add_result0", 32'(rsp_result_0), 32'd1);
        chk("add_flag0", 32'(rsp_flag_0), 1);
        wait_idle();

        // Subtraction on channel 1: borrow, no borrow, equal operands.
        send(1, 1'b1, 4'd3, 4'd5);
        tick();
        chk("sub_3_5_result", 32'(rsp_result_1), 32'hE);
        chk("sub_3_5_flag", 32'(rsp_flag_1), 1);
        wait_idle();
        send(1, 1'b1, 4'd5, 4'd3);
        tick();
        chk("sub_5_3_result", 32'(rsp_result_1), 32'd2);
        chk("sub_5_3_flag", 32'(rsp_flag_1), 0);
        wait_idle();
        send(1, 1'b1, 4'd7, 4'd7);
        tick();
        chk("sub_7_7_result", 32'(rsp_result_1), 32'd0);
        chk("sub_7_7_flag", 32'(rsp_flag_1), 0);
        wait_idle();

        // Continuous contention straight out of reset: strict alternation starting at 0.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        glog.delete();
        gcyc.delete();
        req_valid_0 = 1'b1; req_op_0 = 1'b0; req_a_0 = 4'd15; req_b_0 = 4'd1;
        req_valid_1 = 1'b1; req_op_1 = 1'b1; req_a_1 = 4'd0;  req_b_1 = 4'd1;
        for (int i = 0; i < 40 && glog.size() < 4; i++) tick();
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        if (glog.size() < 4) chk("contention_grants", glog.size(), 4);
        else begin
            chk("grant_order_0", glog[0], 0);
            chk("grant_order_1", glog[1], 1);
            chk("grant_order_2", glog[2], 0);
            chk("grant_order_3", glog[3], 1);
            chk("grant_spacing_alt", gcyc[1] - gcyc[0], 3);
            chk("grant_period_ch0", gcyc[2] - gcyc[0], 6);
            chk("grant_period_ch1", gcyc[3] - gcyc[1], 6);
        end
        wait_idle();

        // Response backpressure: result held stable, no acceptance while waiting.
        rsp_ready_0 = 1'b0;
        send(0, 1'b0, 4'd6, 4'd7);
        tick();
        req_valid_1 = 1'b1; req_op_1 = 1'b0; req_a_1 = 4'd2; req_b_1 = 4'd2;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid0", 32'(rsp_valid_0), 1);
            chk("stall_result0", 32'(rsp_result_0), 32'd13);
            chk("stall_flag0", 32'(rsp_flag_0), 0);
            chk("stall_ready0", 32'(req_ready_0), 0);
            chk("stall_ready1", 32'(req_ready_1), 0);
            chk("stall_busy", 32'(busy), 1);
            tick();
        end
        rsp_ready_0 = 1'b1;
        send(1, 1'b0, 4'd2, 4'd2);
        wait_idle();

        // Reset during EXEC drops the op; the next op proceeds normally.
        send(0, 1'b0, 4'd4, 4'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rsp_valid0", 32'(rsp_valid_0), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_rsp0", 32'(rsp_valid_0), 0);
        end
        send(0, 1'b1, 4'd1, 4'd2);
        tick();
        chk("post_rst_result0", 32'(rsp_result_0), 32'hF);
        chk("post_rst_flag0", 32'(rsp_flag_0), 1);
        wait_idle();

        // Random traffic on both channels with random response backpressure.
        d0 = 1'b0;
        d1 = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send(0, 1'($urandom), 4'($urandom), 4'($urandom));
                end
                d0 = 1'b1;
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send(1, 1'($urandom), 4'($urandom), 4'($urandom));
                end
                d1 = 1'b1;
            end
            begin
                while (!(d0 && d1)) begin
                    rsp_ready_0 = 1'($urandom_range(0, 1));
                    rsp_ready_1 = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        rsp_ready_0 = 1'b1;
        rsp_ready_1 = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
